// File: rtl/mem_data_handler.sv
// Load/store engine between the register bank and the data memory bus.
// Issues one req/ack bus access per start, with byte lanes, alignment checks and a timeout.
module mem_data_handler #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        signext,
    input  logic [31:0] Address,
    input  logic [31:0] StoreData,
    output logic [31:0] LoadData,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  dbg_state
);

    // Bus handshake: mem_req (with mem_we/addr/wdata/wmask) is held high from the
    // cycle after start until the first edge that samples mem_ack=1; that edge
    // completes the access. mem_ack is ignored whenever mem_req is low.

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] count;
    logic          we_q, signext_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, wdata_q;
    logic [31:0]   lane, ext;
    logic [3:0]    mask;
    logic          misaligned;

    assign misaligned = (size == 2'd3) ||
                        (size == 2'd1 && Address[0]) ||
                        (size == 2'd2 && Address[1:0] != 2'b00);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = misaligned ? FAULT : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    next_state = DONE;
                end else if (count == LAST) begin
                    next_state = FAULT;
                end
            end
            DONE:    next_state = IDLE;
            FAULT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            we_q      <= 1'b0;
            signext_q <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            LoadData  <= '0;
        end else begin
            if (state == IDLE && start && !misaligned) begin
                we_q      <= we;
                signext_q <= signext;
                size_q    <= size;
                addr_q    <= Address;
                wdata_q   <= StoreData;
                count     <= '0;
            end
            if (state == REQ && !mem_ack) begin
                count <= count + CW'(1);
            end
            if (state == REQ && mem_ack && !we_q) begin
                LoadData <= ext;
            end
        end
    end

    // Shift the addressed lane down to bit 0, then extend according to size.
    always_comb begin
        lane = mem_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    ext = {{24{signext_q & lane[7]}}, lane[7:0]};
            2'd1:    ext = {{16{signext_q & lane[15]}}, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_comb begin
        mask      = 4'b1111;
        mem_wdata = wdata_q;
        case (size_q)
            2'd0: begin
                mask      = 4'b0001 << addr_q[1:0];
                mem_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                mask      = 4'b0011 << addr_q[1:0];
                mem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                mask      = 4'b1111;
                mem_wdata = wdata_q;
            end
        endcase
    end

    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_wmask = (mem_req && we_q) ? mask : 4'b0000;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fault     = (state == FAULT);
    assign dbg_state = state;

endmodule
